johnson_phase_sequencer: RTL

//  Run controller for a WIDTH-bit Johnson ring that produces 2*WIDTH sequential phase enables.

---
 rtl/johnson_seq_pkg.sv | 44 ++++
 rtl/johnson_ring_core.sv | 21 ++
 rtl/johnson_phase_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/johnson_seq_pkg.sv
// Shared types and helpers for the Johnson phase sequencer.
//   seq_state_e    : run-controller states
//   johnson_legal  : 1 when a w-bit code is one of the 2*w Johnson codes
//   johnson_idx    : step index 0..2*w-1 of a legal w-bit Johnson code
package johnson_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOPPING,
    S_DONE
  } seq_state_e;

  // Helpers take a zero-extended code so one function serves any ring width.
  localparam int JMAX = 32;

  // Legal codes are a contiguous block of k ones, either at the LSB end or
  // at the MSB end of the w-bit field (k = 0..w covers all-zero and all-one).
  function automatic logic johnson_legal(input logic [JMAX-1:0] code, input int w);
    logic            ok;
    logic [JMAX-1:0] ones;
    ok = 1'b0;
    for (int k = 0; k <= JMAX; k++) begin
      if (k <= w) begin
        ones = (k == 0) ? '0 : ({JMAX{1'b1}} >> (JMAX - k));
        if (code == ones || code == (ones << (w - k))) ok = 1'b1;
      end
    end
    return ok;
  endfunction

  // Filling phase (MSB set, or empty) counts ones; draining phase counts
  // back from 2*w.
  function automatic int johnson_idx(input logic [JMAX-1:0] code, input int w);
    int pc;
    pc = 0;
    for (int k = 0; k < JMAX; k++) begin
      if (k < w) pc += int'(code[k]);
    end
    if (code == '0 || code[w-1]) return pc;
    return 2 * w - pc;
  endfunction

endpackage

// File: rtl/johnson_ring_core.sv
// WIDTH-bit Johnson ring register.
//   clk, reset : clock, synchronous active-high reset
//   en         : advance one Johnson step
//   clr        : force ring to all-zero (wins over en)
//   ring       : current code
module johnson_ring_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] ring
);

  always_ff @(posedge clk) begin
    if (reset || clr) ring <= '0;
    else if (en)      ring <= {~ring[0], ring[WIDTH-1:1]};
  end

endmodule

// File: rtl/johnson_phase_sequencer.sv
// Run controller around a Johnson ring: runs N full rotations (or free-runs
// when N=0), decodes one-hot phase strobes, counts rotations, and recovers
// from illegal ring codes.
//   clk, reset  : clock, synchronous active-high reset
//   start       : run request, honoured only in IDLE
//   num_cycles  : rotations to run (0 = free-run), captured on start
//   stop        : finish current rotation, then DONE (RUN only)
//   abort       : immediate return to IDLE, no done pulse
//   busy, done  : run active / one-cycle completion pulse
//   ring        : current Johnson code
//   phase       : one-hot strobe, zero unless busy
//   phase_idx   : step index decoded from ring
//   rot_count   : completed rotations this run
//   err         : sticky illegal-code flag
module johnson_phase_sequencer
  import johnson_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  localparam int PH_W  = 2 * WIDTH,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic             stop,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ring,
  output logic [PH_W-1:0]  phase,
  output logic [IDX_W-1:0] phase_idx,
  output logic [CNT_W-1:0] rot_count,
  output logic             err
);

  seq_state_e       state, state_n;
  logic [CNT_W-1:0] target;
  logic [WIDTH-1:0] ring_q, ring_cur;
  logic             ring_en, ring_clr, cnt_inc, err_set, capture;
  logic             in_run, illegal, wrap, hit;
  logic [CNT_W-1:0] rot_inc;

  johnson_ring_core #(.WIDTH(WIDTH)) u_ring (
    .clk   (clk),
    .reset (reset),
    .en    (ring_en),
    .clr   (ring_clr),
    .ring  (ring_q)
  );

  // Single continuously-driven view of the ring used by all decode logic.
  assign ring_cur = ring_q;
  assign ring     = ring_cur;

  assign in_run  = (state == S_RUN) || (state == S_STOPPING);
  assign illegal = in_run && !johnson_legal(JMAX'(ring_cur), WIDTH);
  // 0..01 steps to all-zero on this edge: a rotation completes.
  assign wrap    = in_run && (ring_cur == WIDTH'(1));
  assign rot_inc = rot_count + 1'b1;
  assign hit     = (target != '0) && (rot_inc == target);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state: abort > illegal recovery > wrap/stop
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_RUN;
      S_RUN: begin
        if (abort)                    state_n = S_IDLE;
        else if (illegal)             state_n = S_RUN;
        else if (wrap && (hit || stop)) state_n = S_DONE;
        else if (stop && !wrap)       state_n = S_STOPPING;
      end
      S_STOPPING: begin
        if (abort)        state_n = S_IDLE;
        else if (illegal) state_n = S_STOPPING;
        else if (wrap)    state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath controls
  always_comb begin
    capture  = (state == S_IDLE) && start;
    ring_en  = in_run && !abort && !illegal;
    ring_clr = in_run && (abort || illegal);
    cnt_inc  = ring_en && wrap;
    err_set  = in_run && !abort && illegal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target    <= '0;
      rot_count <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (capture) begin
        target    <= num_cycles;
        rot_count <= '0;
        err       <= 1'b0;
      end else begin
        if (cnt_inc) rot_count <= rot_inc;
        if (err_set) err       <= 1'b1;
      end
      busy <= (state_n == S_RUN) || (state_n == S_STOPPING);
      done <= (state_n == S_DONE);
    end
  end

  assign phase_idx = IDX_W'(johnson_idx(JMAX'(ring_cur), WIDTH));
  assign phase     = busy ? (PH_W'(1) << phase_idx) : '0;

endmodule
